// File: rtl/ccg_lut_bank.sv
// ccg_lut_bank: a bank of N_FUNC programmable N_IN-input Boolean functions,
// each held as a 2^N_IN-bit truth table. All functions are evaluated in
// parallel over a valid/ready stream. New tables are written into a shadow
// bank at run time and copied to the active bank only after the pipeline
// has drained, so every in-flight result uses one consistent table set.
// Optional build macro: CCG_LUT_OUTREG_EN (adds the S2 output register,
// giving a flop-driven f and a latency of 2 instead of 1).
module ccg_lut_bank #(
  parameter int N_IN   = 2,
  parameter int N_FUNC = 19,
  parameter int IDX_W  = (N_FUNC > 1) ? $clog2(N_FUNC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_FUNC-1:0]    f,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [(1<<N_IN)-1:0] cfg_data,
  input  logic                 cfg_commit,
  output logic                 cfg_busy,
  output logic                 cfg_err
);

  localparam int TBL_W = 1 << N_IN;
  // N_FUNC widened by one bit so the range check also works when N_FUNC == 2^IDX_W
  localparam logic [IDX_W:0] NF_EXT = (IDX_W+1)'(N_FUNC);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_COPY  = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [N_FUNC-1:0][TBL_W-1:0] shadow_q;
  logic [N_FUNC-1:0][TBL_W-1:0] active_q;
  logic                         err_q;
  logic                         s1_valid_q;
  logic [N_IN-1:0]              s1_x_q;
  logic                         s1_load;
  logic                         pipe_empty;
  logic                         in_fire;
  logic                         cfg_fire;
  logic                         idx_ok;
  logic [N_FUNC-1:0]            f_comb;

  assign in_ready  = (state_q == ST_IDLE) && s1_load;
  assign in_fire   = in_valid && in_ready;
  assign cfg_ready = (state_q == ST_IDLE);
  assign cfg_busy  = (state_q != ST_IDLE);
  assign cfg_err   = err_q;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign idx_ok    = ({1'b0, cfg_idx} < NF_EXT);

  // Look up every function's truth table at the S1 input vector
  always_comb begin
    f_comb = '0;
    for (int unsigned k = 0; k < N_FUNC; k++) begin
      f_comb[k] = active_q[k][s1_x_q];
    end
  end

`ifdef CCG_LUT_OUTREG_EN
  logic              s2_valid_q;
  logic [N_FUNC-1:0] s2_f_q;
  logic              s2_load;

  assign s2_load    = !s2_valid_q || out_ready;
  assign s1_load    = !s1_valid_q || s2_load;
  assign pipe_empty = !s1_valid_q && !s2_valid_q;
  assign out_valid  = s2_valid_q;
  assign f          = s2_f_q;

  // S2: register the looked-up results; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_f_q     <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_f_q <= f_comb;
    end
  end
`else
  assign s1_load    = !s1_valid_q || out_ready;
  assign pipe_empty = !s1_valid_q;
  assign out_valid  = s1_valid_q;
  assign f          = f_comb;
`endif

  // S1: capture the accepted input vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_fire;
      if (in_fire) s1_x_q <= x;
    end
  end

  // Commit control: drain the pipeline, copy shadow to active, resume
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_commit) state_d = ST_DRAIN;
      ST_DRAIN: if (pipe_empty) state_d = ST_COPY;
      ST_COPY:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Shadow writes and sticky out-of-range error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else if (cfg_fire) begin
      if (idx_ok) shadow_q[cfg_idx] <= cfg_data;
      else        err_q <= 1'b1;
    end
  end

  // Active tables change only in COPY, when no result is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active_q <= '0;
    else if (state_q == ST_COPY) active_q <= shadow_q;
  end

endmodule

// File: tb/tb_ccg_lut_bank.sv
// Self-checking bench for ccg_lut_bank: directed table vectors, hand-written
// commit/back-pressure/reset sequences and a randomized phase scored against
// a table-level reference model.
module tb_ccg_lut_bank;

  localparam int N_IN   = 2;
  localparam int N_FUNC = 19;
  localparam int IDX_W  = 5;
  localparam int TBL_W  = 4;
`ifdef CCG_LUT_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   x;
  logic              out_valid;
  logic              out_ready;
  logic [N_FUNC-1:0] f;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [IDX_W-1:0]  cfg_idx;
  logic [TBL_W-1:0]  cfg_data;
  logic              cfg_commit;
  logic              cfg_busy;
  logic              cfg_err;

  ccg_lut_bank #(.N_IN(N_IN), .N_FUNC(N_FUNC), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .f(f),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  typedef struct {
    logic [N_FUNC-1:0] f;
    int                acc;
  } item_t;

  logic [TBL_W-1:0]  m_shadow [N_FUNC];
  logic [TBL_W-1:0]  m_active [N_FUNC];
  logic              m_err;
  logic              m_pending;
  item_t             q[$];
  logic [N_FUNC-1:0] cap[$];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [N_FUNC-1:0] last_f;
  int                last_lat;
  logic g_in_f, g_out_f, g_cfg_f, g_busy, g_in_rdy;

  typedef struct {
    logic [N_IN-1:0]   xv;
    logic [N_FUNC-1:0] exp_f;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // f[k] is the x-th bit of table k, taken arithmetically
  function automatic logic [N_FUNC-1:0] eval(input logic [N_IN-1:0] xv);
    logic [N_FUNC-1:0] r;
    r = '0;
    for (int k = 0; k < N_FUNC; k++)
      r[k] = ((int'(m_active[k]) >> int'(xv)) % 2) == 1;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_FUNC; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_err     = 1'b0;
    m_pending = 1'b0;
    q.delete();
  endtask

  // One clock: called at a negedge with inputs already driven; returns at the next negedge
  task automatic tick();
    item_t it;
    #1;
    g_in_f   = in_valid && in_ready;
    g_out_f  = out_valid && out_ready;
    g_cfg_f  = cfg_valid && cfg_ready;
    g_busy   = cfg_busy;
    g_in_rdy = in_ready;
    chk("cfg_err", 64'(cfg_err), 64'(m_err));
    if (m_pending) chk("in_ready_during_commit", 64'(in_ready), 64'(0));
    if (g_out_f) begin
      if (q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_output: got f=%0h expected no output", f);
      end else begin
        it = q.pop_front();
        chk("f_scoreboard", 64'(f), 64'(it.f));
        last_f   = f;
        last_lat = cyc - it.acc;
        cap.push_back(f);
      end
    end
    if (g_cfg_f) begin
      if (int'(cfg_idx) < N_FUNC) m_shadow[cfg_idx] = cfg_data;
      else                        m_err = 1'b1;
    end
    if (cfg_commit && !g_busy) m_pending = 1'b1;
    if (g_in_f) begin
      it.f   = eval(x);
      it.acc = cyc;
      q.push_back(it);
    end
    if (m_pending && q.size() == 0) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [N_IN-1:0] xv);
    int n = 0;
    in_valid = 1'b1;
    x = xv;
    do begin tick(); n++; end while (!g_in_f && n < 50);
    in_valid = 1'b0;
    if (!g_in_f) fail_now("send_accept");
  endtask

  task automatic wait_out();
    int n = 0;
    do begin tick(); n++; end while (!g_out_f && n < 50);
    if (!g_out_f) fail_now("wait_out");
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic [TBL_W-1:0] data);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_idx   = idx;
    cfg_data  = data;
    do begin tick(); n++; end while (!g_cfg_f && n < 50);
    cfg_valid = 1'b0;
    if (!g_cfg_f) fail_now("cfg_write_accept");
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin tick(); n++; end while (g_busy && n < 50);
    if (g_busy) fail_now("wait_idle");
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    chk("busy_after_commit", 64'(g_busy), 64'(1));
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t zv[4];
    vec_t tv[4];
    int   n;

    // Truth tables: AND=1000, XNOR=1001, NOR=0001 on f[0], f[1], f[2]
    for (int i = 0; i < 4; i++) begin
      zv[i].xv = N_IN'(i); zv[i].exp_f = '0;
    end
    tv[0].xv = 2'd0; tv[0].exp_f = N_FUNC'(3'b110);
    tv[1].xv = 2'd1; tv[1].exp_f = N_FUNC'(3'b000);
    tv[2].xv = 2'd2; tv[2].exp_f = N_FUNC'(3'b000);
    tv[3].xv = 2'd3; tv[3].exp_f = N_FUNC'(3'b011);

    rst_n = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b1;
    cfg_valid = 1'b0; cfg_idx = '0; cfg_data = '0; cfg_commit = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_f",         64'(f),         64'(0));
    chk("rst_cfg_ready", 64'(cfg_ready), 64'(1));
    chk("rst_cfg_busy",  64'(cfg_busy),  64'(0));
    chk("rst_cfg_err",   64'(cfg_err),   64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // No configuration: every function reads 0
    for (int i = 0; i < 4; i++) begin
      send(zv[i].xv);
      wait_out();
      chk("zero_f",   64'(last_f),   64'(zv[i].exp_f));
      chk("zero_lat", 64'(last_lat), 64'(LAT));
    end

    // Program AND/XNOR/NOR; the NOR write shares its cycle with the commit
    cfg_write(5'd0, 4'b1000);
    cfg_write(5'd1, 4'b1001);
    cfg_valid = 1'b1; cfg_idx = 5'd2; cfg_data = 4'b0001; cfg_commit = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    tick();
    chk("busy_after_commit", 64'(g_busy), 64'(1));
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      send(tv[i].xv);
      wait_out();
      chk("tbl_f",   64'(last_f),   64'(tv[i].exp_f));
      chk("tbl_lat", 64'(last_lat), 64'(LAT));
    end

    // Commit under back-pressure: in-flight items keep the old tables
    cfg_write(5'd0, 4'b0110);
    cfg_write(5'd1, 4'b1110);
    cfg_write(5'd2, 4'b1000);
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) send(2'd3);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", 64'(g_in_rdy), 64'(0));
      chk("bp_busy",     64'(g_busy),   64'(1));
    end
    cap.delete();
    out_ready = 1'b1;
    wait_idle();
    chk("bp_in_ready_back", 64'(g_in_rdy), 64'(1));
    chk("bp_drained", 64'(cap.size()), 64'(LAT));
    for (int i = 0; i < cap.size(); i++) chk("bp_old_tbl", 64'(cap[i]), 64'(3'b011));
    send(2'd3);
    wait_out();
    chk("bp_new_tbl", 64'(last_f), 64'(3'b110));

    // Out-of-range write: sticky error, shadow untouched
    cfg_write(5'(N_FUNC), 4'b1111);
    tick();
    chk("oor_err", 64'(cfg_err), 64'(1));
    commit();
    send(2'd3);
    wait_out();
    chk("oor_f_unchanged", 64'(last_f), 64'(3'b110));
    repeat (5) tick();
    chk("oor_err_sticky", 64'(cfg_err), 64'(1));

    // Reset while draining
    out_ready = 1'b0;
    send(2'd1);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  64'(in_ready),  64'(1));
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_f",         64'(f),         64'(0));
    chk("mid_rst_cfg_ready", 64'(cfg_ready), 64'(1));
    chk("mid_rst_cfg_busy",  64'(cfg_busy),  64'(0));
    chk("mid_rst_cfg_err",   64'(cfg_err),   64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(2'd3);
    wait_out();
    chk("post_rst_f", 64'(last_f), 64'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 2) == 1;
      x         = N_IN'($urandom);
      out_ready = ($urandom % 4) != 0;
      cfg_valid = ($urandom % 6) == 0;
      if (($urandom % 40) == 0) cfg_idx = IDX_W'($urandom_range(N_FUNC, 31));
      else                      cfg_idx = IDX_W'($urandom_range(0, N_FUNC - 1));
      cfg_data   = TBL_W'($urandom);
      cfg_commit = ($urandom % 25) == 0;
      tick();
    end
    in_valid = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0; out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || g_busy) && n < 50) begin tick(); n++; end
    chk("final_drain", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
